aurora_chdr_channel_mux: RTL and testbench

AURORA_CHDR_CHANNEL_MUX -- requirements
Module: aurora_chdr_channel_mux

---
 rtl/aurora_pkg.sv | 18 +
 rtl/aurora_axis_out_reg.sv | 30 +++
 rtl/aurora_chdr_channel_mux.sv | 153 +++++++++++++++
 tb/tb_aurora_chdr_channel_mux.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared constants and FSM encoding for the CHDR-to-Aurora channel mux.
// Holds the location of the CHDR virtual-channel field within the first beat.
package aurora_pkg;

    localparam int CHDR_VC_MSB = 63;
    localparam int CHDR_VC_LSB = 58;
    localparam int CHDR_VC_W   = 6;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } mux_state_t;

    function automatic logic [CHDR_VC_W-1:0] chdr_vc(input int port, input int offset);
        return CHDR_VC_W'(port + offset);
    endfunction

endpackage

// File: rtl/aurora_axis_out_reg.sv
// Single-entry full-throughput AXI-stream register slice; one cycle latency.
// Accepts a new beat whenever empty or draining; holds its output stable while stalled.
module aurora_axis_out_reg #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/aurora_chdr_channel_mux.sv
// Round-robin packet mux of CHDR ports onto one Aurora stream, stamping the VC field.
// Output is registered (1 cycle); a stalled Aurora link backpressures only the granted port.
module aurora_chdr_channel_mux
    import aurora_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int AURORA_W       = 256,
    parameter int CHANNEL_OFFSET = 0
) (
    input  logic                               aurora_clk,
    input  logic                               aurora_rst_n,
    input  logic [NUM_PORTS-1:0][AURORA_W-1:0] s_chdr_tdata,
    input  logic [NUM_PORTS-1:0]               s_chdr_tvalid,
    input  logic [NUM_PORTS-1:0]               s_chdr_tlast,
    output logic [NUM_PORTS-1:0]               s_chdr_tready,
    output logic [AURORA_W-1:0]                m_aurora_tdata,
    output logic                               m_aurora_tvalid,
    output logic                               m_aurora_tlast,
    input  logic                               m_aurora_tready,
    output logic [NUM_PORTS-1:0][31:0]         pkt_count
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

    if (NUM_PORTS < 1 || NUM_PORTS + CHANNEL_OFFSET > 64 || AURORA_W < 64) begin : g_bad_params
        $error("aurora_chdr_channel_mux: illegal NUM_PORTS/CHANNEL_OFFSET/AURORA_W");
    end

    // Assert asynchronously, release two edges after the pin deasserts.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge aurora_clk or negedge aurora_rst_n) begin
        if (!aurora_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    mux_state_t                  state;
    logic [GW-1:0]               grant;
    logic [GW-1:0]               last_grant;
    logic                        first_beat;
    logic [NUM_PORTS-1:0][31:0]  pkt_cnt_q;

    logic [GW-1:0]               rr_next;
    logic                        rr_any;
    int                          rr_idx;

    // Scan from the far end so the nearest requester after last_grant wins.
    always_comb begin
        rr_next = last_grant;
        rr_any  = 1'b0;
        rr_idx  = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            rr_idx = (int'(last_grant) + i) % NUM_PORTS;
            if (s_chdr_tvalid[rr_idx]) begin
                rr_next = GW'(rr_idx);
                rr_any  = 1'b1;
            end
        end
    end

    logic [AURORA_W-1:0] sel_dat;
    logic                sel_vld;
    logic                sel_last;
    logic [AURORA_W-1:0] ins_dat;
    logic                reg_in_vld;
    logic                reg_in_rdy;
    logic                accept;

    assign sel_dat    = s_chdr_tdata[grant];
    assign sel_vld    = s_chdr_tvalid[grant];
    assign sel_last   = s_chdr_tlast[grant];
    assign reg_in_vld = (state == PASS) && sel_vld;
    assign accept     = reg_in_vld && reg_in_rdy;

    always_comb begin
        ins_dat = sel_dat;
        if (first_beat) begin
            ins_dat[CHDR_VC_MSB:CHDR_VC_LSB] = chdr_vc(int'(grant), CHANNEL_OFFSET);
        end
    end

    always_comb begin
        s_chdr_tready = '0;
        if (state == PASS) begin
            s_chdr_tready[grant] = reg_in_rdy;
        end
    end

    always_ff @(posedge aurora_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        grant      <= rr_next;
                        first_beat <= 1'b1;
                        state      <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (sel_last) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aurora_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else if (accept && sel_last) begin
            pkt_cnt_q[grant] <= pkt_cnt_q[grant] + 32'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;

    logic [AURORA_W:0] out_bus;

    aurora_axis_out_reg #(
        .W (AURORA_W + 1)
    ) u_out_reg (
        .clk     (aurora_clk),
        .rst_n   (rst_n),
        .in_dat  ({sel_last, ins_dat}),
        .in_vld  (reg_in_vld),
        .in_rdy  (reg_in_rdy),
        .out_dat (out_bus),
        .out_vld (m_aurora_tvalid),
        .out_rdy (m_aurora_tready)
    );

    assign m_aurora_tlast = out_bus[AURORA_W];
    assign m_aurora_tdata = out_bus[AURORA_W-1:0];

endmodule

// File: tb/tb_aurora_chdr_channel_mux.sv
// Directed bench for aurora_chdr_channel_mux with a beat scoreboard and gap/stall monitor.
module tb_aurora_chdr_channel_mux;

    localparam int NP  = 2;
    localparam int W   = 128;
    localparam int OFF = 2;

    typedef struct packed {
        logic         last;
        logic [W-1:0] dat;
    } beat_t;

    logic                  aurora_clk;
    logic                  aurora_rst_n;
    logic [NP-1:0][W-1:0]  s_chdr_tdata;
    logic [NP-1:0]         s_chdr_tvalid;
    logic [NP-1:0]         s_chdr_tlast;
    logic [NP-1:0]         s_chdr_tready;
    logic [W-1:0]          m_aurora_tdata;
    logic                  m_aurora_tvalid;
    logic                  m_aurora_tlast;
    logic                  m_aurora_tready;
    logic [NP-1:0][31:0]   pkt_count;

    aurora_chdr_channel_mux #(
        .NUM_PORTS      (NP),
        .AURORA_W       (W),
        .CHANNEL_OFFSET (OFF)
    ) dut (
        .aurora_clk      (aurora_clk),
        .aurora_rst_n    (aurora_rst_n),
        .s_chdr_tdata    (s_chdr_tdata),
        .s_chdr_tvalid   (s_chdr_tvalid),
        .s_chdr_tlast    (s_chdr_tlast),
        .s_chdr_tready   (s_chdr_tready),
        .m_aurora_tdata  (m_aurora_tdata),
        .m_aurora_tvalid (m_aurora_tvalid),
        .m_aurora_tlast  (m_aurora_tlast),
        .m_aurora_tready (m_aurora_tready),
        .pkt_count       (pkt_count)
    );

    initial aurora_clk = 1'b0;
    always #5 aurora_clk = ~aurora_clk;

    int          tests = 0;
    int          fails = 0;
    beat_t       src_q[NP][$];
    beat_t       exp_q[$];
    int          gap_q[$];
    logic [31:0] exp_cnt[NP];
    logic [NP-1:0] hs;
    int          cyc = 0;
    int          out_beats = 0;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a packet on port p and its expected output beats.
    task automatic send(input int p, input int nbeats);
        beat_t b;
        beat_t e;
        for (int i = 0; i < nbeats; i++) begin
            b.dat  = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.last = (i == nbeats - 1);
            e = b;
            if (i == 0) e.dat[63:58] = 6'(p + OFF);
            src_q[p].push_back(b);
            exp_q.push_back(e);
        end
        exp_cnt[p] = exp_cnt[p] + 32'd1;
    endtask

    function automatic bit src_busy();
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_q.size() > 0 || src_busy()) && n < max_cyc) begin
            @(negedge aurora_clk);
            n++;
        end
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s: drain timeout, %0d beats outstanding, expected 0", tag, exp_q.size());
        end
        repeat (3) @(negedge aurora_clk);
    endtask

    task automatic wait_beats(input string tag, input int target, input int max_cyc);
        int n = 0;
        while (out_beats < target && n < max_cyc) begin
            @(negedge aurora_clk);
            n++;
        end
        tests++;
        assert (out_beats >= target) else begin
            fails++;
            $error("FAIL %s: beat wait timeout, got %0d beats expected %0d", tag, out_beats, target);
        end
    endtask

    task automatic check_gaps(input string tag, input int npkts);
        check({tag, "_npkts"}, (W+1)'(gap_q.size()), (W+1)'(npkts));
        if (gap_q.size() > 0) void'(gap_q.pop_front());
        while (gap_q.size() > 0) check({tag, "_gap"}, (W+1)'(gap_q.pop_front()), (W+1)'(2));
    endtask

    // Source driver: present queue heads, pop after each handshake.
    initial begin
        s_chdr_tdata  = '0;
        s_chdr_tvalid = '0;
        s_chdr_tlast  = '0;
        hs            = '0;
        forever begin
            @(negedge aurora_clk);
            hs = s_chdr_tvalid & s_chdr_tready;
            @(posedge aurora_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_chdr_tvalid[p] = 1'b1;
                    s_chdr_tdata[p]  = src_q[p][0].dat;
                    s_chdr_tlast[p]  = src_q[p][0].last;
                end else begin
                    s_chdr_tvalid[p] = 1'b0;
                    s_chdr_tlast[p]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare, stall stability, inter-packet gap.
    initial begin
        beat_t held;
        beat_t got;
        beat_t e;
        bit    stall_hold = 1'b0;
        bit    prev_last  = 1'b1;
        int    last_end   = 0;
        forever begin
            @(negedge aurora_clk);
            cyc++;
            if (!aurora_rst_n) begin
                stall_hold = 1'b0;
                prev_last  = 1'b1;
                continue;
            end
            got = {m_aurora_tlast, m_aurora_tdata};
            if (stall_hold) begin
                check("stall_vld", (W+1)'(m_aurora_tvalid), (W+1)'(1));
                check("stall_dat", got, held);
            end
            if (m_aurora_tvalid && m_aurora_tready) begin
                out_beats++;
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_beat: got %0h expected no beat", got);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat", got, e);
                end
                if (prev_last) gap_q.push_back(cyc - last_end);
                prev_last = m_aurora_tlast;
                if (m_aurora_tlast) last_end = cyc;
                stall_hold = 1'b0;
            end else if (m_aurora_tvalid) begin
                stall_hold = 1'b1;
                held       = got;
            end else begin
                stall_hold = 1'b0;
            end
        end
    end

    initial begin
        int base;
        logic [3:0] rdy_seq;
        for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
        aurora_rst_n    = 1'b0;
        m_aurora_tready = 1'b1;
        repeat (3) @(negedge aurora_clk);

        check("rst_tvalid", (W+1)'(m_aurora_tvalid), '0);
        check("rst_tlast",  (W+1)'(m_aurora_tlast),  '0);
        check("rst_tready", (W+1)'(s_chdr_tready),   '0);
        check("rst_cnt",    (W+1)'(pkt_count),       '0);

        // Port 1 alone, 4 beats, queued during reset to probe release timing.
        send(1, 4);
        @(negedge aurora_clk);
        aurora_rst_n = 1'b1;
        @(posedge aurora_clk); #1;
        check("sync_edge1_tready", (W+1)'(s_chdr_tready), '0);
        @(posedge aurora_clk); #1;
        check("sync_edge2_tready", (W+1)'(s_chdr_tready), '0);
        wait_drain("p1_4beat", 50);
        check("p1_cnt1", (W+1)'(pkt_count[1]), (W+1)'(exp_cnt[1]));
        check("p1_cnt0", (W+1)'(pkt_count[0]), (W+1)'(exp_cnt[0]));

        // Both ports continuously requesting: expect 0,1,0,1 with single idle gaps.
        gap_q.delete();
        send(0, 3); send(1, 3); send(0, 3); send(1, 3);
        wait_drain("rr_alt", 100);
        check_gaps("rr_alt", 4);
        check("rr_cnt0", (W+1)'(pkt_count[0]), (W+1)'(exp_cnt[0]));
        check("rr_cnt1", (W+1)'(pkt_count[1]), (W+1)'(exp_cnt[1]));

        // Aurora stall mid-packet.
        base = out_beats;
        send(0, 6);
        wait_beats("stall_start", base + 2, 50);
        rdy_seq = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            @(posedge aurora_clk); #1;
            m_aurora_tready = rdy_seq[i];
        end
        @(posedge aurora_clk); #1;
        m_aurora_tready = 1'b1;
        wait_drain("stall", 50);
        check("stall_cnt0", (W+1)'(pkt_count[0]), (W+1)'(exp_cnt[0]));

        // Counter wrap from a forced all-ones value.
        force dut.pkt_cnt_q = {exp_cnt[1], 32'hFFFF_FFFF};
        @(posedge aurora_clk); #1;
        release dut.pkt_cnt_q;
        exp_cnt[0] = 32'hFFFF_FFFF;
        send(0, 2);
        wait_drain("wrap", 50);
        check("wrap_cnt0", (W+1)'(pkt_count[0]), (W+1)'(32'h0));
        check("wrap_cnt1", (W+1)'(pkt_count[1]), (W+1)'(exp_cnt[1]));

        // Back-to-back single-beat packets on port 0.
        gap_q.delete();
        for (int i = 0; i < 5; i++) send(0, 1);
        wait_drain("one_beat", 60);
        check_gaps("one_beat", 5);
        check("one_beat_cnt0", (W+1)'(pkt_count[0]), (W+1)'(exp_cnt[0]));

        // Reset on beat 2 of a 5-beat packet.
        base = out_beats;
        send(1, 5);
        wait_beats("rst_mid_start", base + 2, 50);
        #2;
        aurora_rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_cnt[p] = '0;
        end
        exp_q.delete();
        #1;
        check("midrst_tvalid", (W+1)'(m_aurora_tvalid), '0);
        check("midrst_tready", (W+1)'(s_chdr_tready),   '0);
        check("midrst_cnt",    (W+1)'(pkt_count),       '0);
        repeat (3) @(negedge aurora_clk);
        aurora_rst_n = 1'b1;
        repeat (4) @(negedge aurora_clk);
        send(0, 3);
        wait_drain("post_rst", 50);
        check("post_rst_cnt0", (W+1)'(pkt_count[0]), (W+1)'(exp_cnt[0]));
        check("post_rst_cnt1", (W+1)'(pkt_count[1]), (W+1)'(exp_cnt[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
